// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports (m0 = core load/store, m1 = boot loader / DMA)
//   and the DMemory-side port of the data-memory arbiter.
//
//   Handshake: a requester raises mN_req with we/addr/wdata/wmask and holds all of
//   them stable until it sees mN_gnt high at a rising edge. That edge is the accept
//   point, and a write is complete there. A read returns later as a single-cycle
//   mN_rvalid pulse with mN_rdata. If mN_rerr is also set, the read timed out and
//   the data is the error word. There is no back-pressure on the read response.
//
//   Modports:
//     slave  - the arbiter (samples requests and memory return, drives grants/strobes)
//     master - the requesters and the memory model around it
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_rerr;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_rerr;

  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
    output m0_gnt, m0_rvalid, m0_rdata, m0_rerr,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
    output m1_gnt, m1_rvalid, m1_rdata, m1_rerr,
    output mem_re, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_rvalid
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_rerr,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_rerr,
    input  mem_re, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single DMemory port between the pipeline core (m0) and the boot
//   loader / DMA engine (m1). It issues at most one access per cycle and allows
//   one outstanding read. Arbitration is round-robin, or m0 wins fixed when
//   FIXED_PRIO=1. A read that gets no memory return within TIMEOUT cycles ends
//   with ERR_WORD and rerr set.
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   bus          dmem_arbiter_if.slave: requester ports m0/m1 and the DMemory port
//   dbg_state_o  FSM state (0 = IDLE, 1 = RD_WAIT)
module dmem_arbiter #(
  parameter int          FIXED_PRIO = 0,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_WORD   = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        bus,
  output logic                 dbg_state_o
);
  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_gnt_q, last_gnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic        win;
  logic        gnt0, gnt1;
  logic        rv0, rv1, rerr;
  logic [31:0] rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;  // m0 wins the first tie after reset
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    win        = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rv0        = 1'b0;
    rv1        = 1'b0;
    rerr       = 1'b0;
    rdata      = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;

    // While rst is high every output stays 0, even though requests may be present.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (bus.m0_req && bus.m1_req) win = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt_q;
          else                          win = bus.m1_req;

          if (bus.m0_req || bus.m1_req) begin
            gnt0       = ~win;
            gnt1       = win;
            mem_we     = win ? bus.m1_we    : bus.m0_we;
            mem_re     = ~mem_we;
            mem_addr   = win ? bus.m1_addr  : bus.m0_addr;
            mem_wdata  = win ? bus.m1_wdata : bus.m0_wdata;
            mem_wmask  = win ? bus.m1_wmask : bus.m0_wmask;
            last_gnt_d = win;
            if (!mem_we) begin
              owner_d   = win;
              tmo_cnt_d = '0;
              state_d   = RD_WAIT;
            end
          end
          // A mem_rvalid seen here is late or spurious and is dropped.
        end

        RD_WAIT: begin
          if (bus.mem_rvalid) begin
            // The memory data goes straight through in the same cycle, adding no latency.
            rv0     = ~owner_q;
            rv1     = owner_q;
            rdata   = bus.mem_rdata;
            state_d = IDLE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            rv0     = ~owner_q;
            rv1     = owner_q;
            rerr    = 1'b1;
            rdata   = ERR_WORD;
            state_d = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rv0;
  assign bus.m1_rvalid = rv1;
  assign bus.m0_rerr   = rv0 & rerr;
  assign bus.m1_rerr   = rv1 & rerr;
  assign bus.m0_rdata  = rv0 ? rdata : 32'h0;
  assign bus.m1_rdata  = rv1 ? rdata : 32'h0;
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wmask = mem_wmask;

  assign dbg_state_o = (state_q == RD_WAIT);
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic clk;
  logic rst;
  logic dbg_rr, dbg_fp;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  dmem_arbiter_if bus_rr ();
  dmem_arbiter_if bus_fp ();

  dmem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(16), .ERR_WORD(32'hDEADBEEF)) u_rr (
    .clk(clk), .rst(rst), .bus(bus_rr), .dbg_state_o(dbg_rr)
  );

  dmem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(16), .ERR_WORD(32'hDEADBEEF)) u_fp (
    .clk(clk), .rst(rst), .bus(bus_fp), .dbg_state_o(dbg_fp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus_rr.m0_req = 0; bus_rr.m0_we = 0; bus_rr.m0_addr = 0; bus_rr.m0_wdata = 0; bus_rr.m0_wmask = 0;
    bus_rr.m1_req = 0; bus_rr.m1_we = 0; bus_rr.m1_addr = 0; bus_rr.m1_wdata = 0; bus_rr.m1_wmask = 0;
    bus_rr.mem_rdata = 0; bus_rr.mem_rvalid = 0;
    bus_fp.m0_req = 0; bus_fp.m0_we = 0; bus_fp.m0_addr = 0; bus_fp.m0_wdata = 0; bus_fp.m0_wmask = 0;
    bus_fp.m1_req = 0; bus_fp.m1_we = 0; bus_fp.m1_addr = 0; bus_fp.m1_wdata = 0; bus_fp.m1_wmask = 0;
    bus_fp.mem_rdata = 0; bus_fp.mem_rvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus_rr.m0_req = 1; bus_rr.m0_we = 0; bus_rr.m0_addr = 32'h44;
    next_cycle();
    sample();
    total_cnt++;
    if (bus_rr.m0_gnt !== 1'b0 || bus_rr.mem_re !== 1'b0 || bus_rr.mem_addr !== 32'h0)
      $display("FAIL reset_outputs: gnt=%b re=%b addr=%h, required 0/0/0",
               bus_rr.m0_gnt, bus_rr.mem_re, bus_rr.mem_addr);
    else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    sample();
    total_cnt++;
    if (dbg_rr !== 1'b0 || bus_rr.m0_rvalid !== 1'b0 || bus_rr.m1_rvalid !== 1'b0 || bus_rr.mem_we !== 1'b0)
      $display("FAIL reset_state: state=%b rv0=%b rv1=%b we=%b, required all 0",
               dbg_rr, bus_rr.m0_rvalid, bus_rr.m1_rvalid, bus_rr.mem_we);
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    do_reset();
    bus_rr.m0_req = 1; bus_rr.m0_we = 0; bus_rr.m0_addr = 32'h90000010;
    sample();
    total_cnt++;
    if (bus_rr.m0_gnt !== 1'b1 || bus_rr.m1_gnt !== 1'b0 || bus_rr.mem_re !== 1'b1 ||
        bus_rr.mem_we !== 1'b0 || bus_rr.mem_addr !== 32'h90000010)
      $display("FAIL read_issue: gnt0=%b gnt1=%b re=%b we=%b addr=%h, required 1/0/1/0/90000010",
               bus_rr.m0_gnt, bus_rr.m1_gnt, bus_rr.mem_re, bus_rr.mem_we, bus_rr.mem_addr);
    else pass_cnt++;
    next_cycle();
    bus_rr.m0_req = 0;
    bus_rr.mem_rvalid = 1; bus_rr.mem_rdata = 32'h12345678;
    exp_q.push_back(32'h12345678);
    sample();
    exp_w = exp_q.pop_front();
    total_cnt++;
    if (bus_rr.m0_rvalid !== 1'b1 || bus_rr.m0_rdata !== exp_w || bus_rr.m0_rerr !== 1'b0)
      $display("FAIL read_return: rvalid=%b rdata=%h rerr=%b, required 1/%h/0",
               bus_rr.m0_rvalid, bus_rr.m0_rdata, bus_rr.m0_rerr, exp_w);
    else pass_cnt++;
    total_cnt++;
    if (bus_rr.m1_rvalid !== 1'b0 || bus_rr.m1_rdata !== 32'h0 || bus_rr.m1_rerr !== 1'b0 || bus_rr.m0_gnt !== 1'b0)
      $display("FAIL read_nonowner: m1 rvalid=%b rdata=%h rerr=%b gnt0=%b, required 0/0/0/0",
               bus_rr.m1_rvalid, bus_rr.m1_rdata, bus_rr.m1_rerr, bus_rr.m0_gnt);
    else pass_cnt++;
    next_cycle();
    bus_rr.mem_rvalid = 0; bus_rr.mem_rdata = 0;
    sample();
    total_cnt++;
    if (dbg_rr !== 1'b0 || bus_rr.m0_rvalid !== 1'b0 || bus_rr.m0_rdata !== 32'h0)
      $display("FAIL read_idle_after: state=%b rvalid=%b rdata=%h, required 0/0/0",
               dbg_rr, bus_rr.m0_rvalid, bus_rr.m0_rdata);
    else pass_cnt++;
  endtask

  task automatic test_rr_writes();
    logic exp_win;
    do_reset();
    bus_rr.m0_req = 1; bus_rr.m0_we = 1; bus_rr.m0_addr = 32'h100; bus_rr.m0_wdata = 32'hAAAA0000; bus_rr.m0_wmask = 4'h3;
    bus_rr.m1_req = 1; bus_rr.m1_we = 1; bus_rr.m1_addr = 32'h200; bus_rr.m1_wdata = 32'hBBBB0000; bus_rr.m1_wmask = 4'hC;
    for (int i = 0; i < 4; i++) begin
      exp_win = i[0];
      bus_rr.m0_wdata = 32'hAAAA0000 + i;
      bus_rr.m1_wdata = 32'hBBBB0000 + i;
      sample();
      total_cnt++;
      if (bus_rr.m0_gnt !== ~exp_win || bus_rr.m1_gnt !== exp_win ||
          bus_rr.mem_wmask !== (exp_win ? 4'hC : 4'h3) || bus_rr.mem_we !== 1'b1 || bus_rr.mem_re !== 1'b0 ||
          bus_rr.mem_wdata !== (exp_win ? 32'hBBBB0000 + i : 32'hAAAA0000 + i))
        $display("FAIL rr_write[%0d]: gnt0=%b gnt1=%b wmask=%h we=%b re=%b wdata=%h, required winner m%0d",
                 i, bus_rr.m0_gnt, bus_rr.m1_gnt, bus_rr.mem_wmask, bus_rr.mem_we, bus_rr.mem_re,
                 bus_rr.mem_wdata, exp_win);
      else pass_cnt++;
      total_cnt++;
      if (bus_rr.m0_rvalid !== 1'b0 || bus_rr.m1_rvalid !== 1'b0 || dbg_rr !== 1'b0)
        $display("FAIL rr_write_norv[%0d]: rv0=%b rv1=%b state=%b, required 0/0/0",
                 i, bus_rr.m0_rvalid, bus_rr.m1_rvalid, dbg_rr);
      else pass_cnt++;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    bus_fp.m0_req = 1; bus_fp.m0_we = 1; bus_fp.m0_addr = 32'h300; bus_fp.m0_wmask = 4'h1;
    bus_fp.m1_req = 1; bus_fp.m1_we = 1; bus_fp.m1_addr = 32'h400; bus_fp.m1_wmask = 4'h8;
    for (int i = 0; i < 4; i++) begin
      sample();
      total_cnt++;
      if (bus_fp.m0_gnt !== 1'b1 || bus_fp.m1_gnt !== 1'b0 || bus_fp.mem_wmask !== 4'h1 || bus_fp.mem_addr !== 32'h300)
        $display("FAIL fixed_prio[%0d]: gnt0=%b gnt1=%b wmask=%h addr=%h, required 1/0/1/00000300",
                 i, bus_fp.m0_gnt, bus_fp.m1_gnt, bus_fp.mem_wmask, bus_fp.mem_addr);
      else pass_cnt++;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    logic exp_rv;
    do_reset();
    bus_rr.m1_req = 1; bus_rr.m1_we = 0; bus_rr.m1_addr = 32'h0000_0F00;
    sample();
    total_cnt++;
    if (bus_rr.m1_gnt !== 1'b1 || bus_rr.mem_re !== 1'b1 || bus_rr.mem_addr !== 32'h0000_0F00)
      $display("FAIL tmo_issue: gnt1=%b re=%b addr=%h, required 1/1/00000f00",
               bus_rr.m1_gnt, bus_rr.mem_re, bus_rr.mem_addr);
    else pass_cnt++;
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      bus_rr.m1_req = 0;
      sample();
      exp_rv = (k == 16);
      total_cnt++;
      if (bus_rr.m1_rvalid !== exp_rv || bus_rr.mem_re !== 1'b0 || bus_rr.m0_rvalid !== 1'b0)
        $display("FAIL tmo_wait[%0d]: rv1=%b re=%b rv0=%b, required %b/0/0",
                 k, bus_rr.m1_rvalid, bus_rr.mem_re, bus_rr.m0_rvalid, exp_rv);
      else pass_cnt++;
      if (k == 16) begin
        total_cnt++;
        if (bus_rr.m1_rerr !== 1'b1 || bus_rr.m1_rdata !== 32'hDEADBEEF)
          $display("FAIL tmo_error: rerr=%b rdata=%h, required 1/deadbeef",
                   bus_rr.m1_rerr, bus_rr.m1_rdata);
        else pass_cnt++;
      end
    end
    next_cycle();
    sample();
    total_cnt++;
    if (dbg_rr !== 1'b0 || bus_rr.m1_rvalid !== 1'b0)
      $display("FAIL tmo_idle: state=%b rv1=%b, required 0/0", dbg_rr, bus_rr.m1_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_rd_wait();
    do_reset();
    bus_rr.m0_req = 1; bus_rr.m0_we = 0; bus_rr.m0_addr = 32'h80;
    next_cycle();
    bus_rr.m0_req = 0;
    rst = 1'b1;
    sample();
    total_cnt++;
    if (bus_rr.m0_rvalid !== 1'b0 || bus_rr.mem_re !== 1'b0)
      $display("FAIL rst_rdwait_during: rv0=%b re=%b, required 0/0", bus_rr.m0_rvalid, bus_rr.mem_re);
    else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    bus_rr.mem_rvalid = 1; bus_rr.mem_rdata = 32'h5555AAAA;
    bus_rr.m0_req = 1; bus_rr.m0_we = 1; bus_rr.m0_addr = 32'hC0; bus_rr.m0_wmask = 4'hF;
    sample();
    total_cnt++;
    if (bus_rr.m0_rvalid !== 1'b0 || bus_rr.m1_rvalid !== 1'b0 || bus_rr.m0_rdata !== 32'h0)
      $display("FAIL rst_late_rvalid: rv0=%b rv1=%b rdata=%h, required 0/0/0",
               bus_rr.m0_rvalid, bus_rr.m1_rvalid, bus_rr.m0_rdata);
    else pass_cnt++;
    total_cnt++;
    if (bus_rr.m0_gnt !== 1'b1 || bus_rr.mem_we !== 1'b1 || bus_rr.mem_addr !== 32'hC0)
      $display("FAIL rst_next_write: gnt0=%b we=%b addr=%h, required 1/1/000000c0",
               bus_rr.m0_gnt, bus_rr.mem_we, bus_rr.mem_addr);
    else pass_cnt++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_write_during_read();
    do_reset();
    bus_rr.m0_req = 1; bus_rr.m0_we = 0; bus_rr.m0_addr = 32'h10;
    sample();
    next_cycle();
    bus_rr.m0_req = 0;
    bus_rr.m1_req = 1; bus_rr.m1_we = 1; bus_rr.m1_addr = 32'h7000; bus_rr.m1_wdata = 32'h0BADF00D; bus_rr.m1_wmask = 4'h6;
    for (int c = 1; c <= 2; c++) begin
      sample();
      total_cnt++;
      if (bus_rr.m1_gnt !== 1'b0 || bus_rr.mem_we !== 1'b0 || bus_rr.mem_addr !== 32'h0)
        $display("FAIL wdr_blocked[%0d]: gnt1=%b we=%b addr=%h, required 0/0/0",
                 c, bus_rr.m1_gnt, bus_rr.mem_we, bus_rr.mem_addr);
      else pass_cnt++;
      next_cycle();
    end
    bus_rr.mem_rvalid = 1; bus_rr.mem_rdata = 32'hCAFEF00D;
    exp_q.push_back(32'hCAFEF00D);
    sample();
    exp_w = exp_q.pop_front();
    total_cnt++;
    if (bus_rr.m0_rvalid !== 1'b1 || bus_rr.m0_rdata !== exp_w || bus_rr.m1_gnt !== 1'b0)
      $display("FAIL wdr_return: rv0=%b rdata=%h gnt1=%b, required 1/%h/0",
               bus_rr.m0_rvalid, bus_rr.m0_rdata, bus_rr.m1_gnt, exp_w);
    else pass_cnt++;
    next_cycle();
    bus_rr.mem_rvalid = 0; bus_rr.mem_rdata = 0;
    sample();
    total_cnt++;
    if (bus_rr.m1_gnt !== 1'b1 || bus_rr.mem_we !== 1'b1 || bus_rr.mem_addr !== 32'h7000 ||
        bus_rr.mem_wdata !== 32'h0BADF00D || bus_rr.mem_wmask !== 4'h6)
      $display("FAIL wdr_granted: gnt1=%b we=%b addr=%h wdata=%h wmask=%h, required 1/1/00007000/0badf00d/6",
               bus_rr.m1_gnt, bus_rr.mem_we, bus_rr.mem_addr, bus_rr.mem_wdata, bus_rr.mem_wmask);
    else pass_cnt++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_spurious_rvalid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus_rr.mem_rvalid = 1;
      bus_rr.mem_rdata = $urandom_range(1, 32'hFFFF);
      sample();
      total_cnt++;
      if (bus_rr.m0_rvalid !== 1'b0 || bus_rr.m1_rvalid !== 1'b0 ||
          bus_rr.m0_rdata !== 32'h0 || bus_rr.m1_rdata !== 32'h0)
        $display("FAIL spurious_rvalid[%0d]: rv0=%b rv1=%b rd0=%h rd1=%h, required all 0",
                 i, bus_rr.m0_rvalid, bus_rr.m1_rvalid, bus_rr.m0_rdata, bus_rr.m1_rdata);
      else pass_cnt++;
      next_cycle();
    end
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_writes();
    test_fixed_prio();
    test_timeout();
    test_reset_in_rd_wait();
    test_write_during_read();
    test_spurious_rvalid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pass=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end
endmodule
